// File: rtl/ixc_tbcall_sched_if.sv
// Backpressured tbcall channel: call issue (valid/ready) plus completion (ack/rsp).
// The master side is the scheduler; the slave side is the testbench-call endpoint.
interface ixc_tbcall_sched_if #(
  parameter int unsigned DW = 32
) ();

  logic          tbc_valid;
  logic [DW-1:0] tbc_data;
  logic          tbc_ready;
  logic          tbc_ack;
  logic [DW-1:0] tbc_rsp;

  modport master (
    output tbc_valid,
    output tbc_data,
    input  tbc_ready,
    input  tbc_ack,
    input  tbc_rsp
  );

  modport slave (
    input  tbc_valid,
    input  tbc_data,
    output tbc_ready,
    output tbc_ack,
    output tbc_rsp
  );

endinterface

// File: rtl/ixc_tbcall_sched.sv
// Round-robin scheduler of one shared tbcall channel among NREQ requesters.
// One call in flight: issue handshake, wait for ack (with optional timeout), one-cycle done.
module ixc_tbcall_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32,
  parameter int unsigned TW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*DW-1:0]   req_data_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      done_o,
  output logic [DW-1:0]        rsp_data_o,
  output logic                 err_timeout_o,
  input  logic [TW-1:0]        timeout_cycles_i,
  output logic                 stray_ack_o,
  ixc_tbcall_sched_if.master   tbc
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e          state_q,  state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   idx_q,    idx_d;
  logic [NREQ-1:0] gnt_q,    gnt_d;
  logic [NREQ-1:0] done_q,   done_d;
  logic [DW-1:0]   rsp_q,    rsp_d;
  logic            err_q,    err_d;
  logic            valid_q,  valid_d;
  logic [DW-1:0]   data_q,   data_d;
  logic            stray_q,  stray_d;
  logic [TW-1:0]   cnt_q,    cnt_d;
  logic [TW-1:0]   limit_q,  limit_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [CW-1:0]   cand;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rsp_q    <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      stray_q  <= 1'b0;
      cnt_q    <= '0;
      limit_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rsp_q    <= rsp_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      stray_q  <= stray_d;
      cnt_q    <= cnt_d;
      limit_q  <= limit_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    rsp_d    = rsp_q;
    err_d    = err_q;
    valid_d  = valid_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    limit_d  = limit_q;
    stray_d  = stray_q | (tbc.tbc_ack & (state_q != S_WAIT));

    // First requester at or above rr_ptr, wrapping modulo NREQ
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(NREQ)) begin
        cand = cand - CW'(NREQ);
      end
      if (!win_found && req_i[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          idx_d   = win_idx;
          gnt_d   = NREQ'(1) << win_idx;
          data_d  = req_data_i[32'(win_idx)*DW +: DW];
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (tbc.tbc_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          limit_d = timeout_cycles_i;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + TW'(1);
        // Ack has priority over a timeout landing in the same cycle
        if (tbc.tbc_ack) begin
          rsp_d   = tbc.tbc_rsp;
          err_d   = 1'b0;
          done_d  = gnt_q;
          state_d = S_DONE;
        end else if ((limit_q != '0) && (cnt_q == limit_q - TW'(1))) begin
          rsp_d   = '0;
          err_d   = 1'b1;
          done_d  = gnt_q;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        rr_ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
        gnt_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign gnt_o         = gnt_q;
  assign done_o        = done_q;
  assign rsp_data_o    = rsp_q;
  assign err_timeout_o = err_q;
  assign stray_ack_o   = stray_q;
  assign tbc.tbc_valid = valid_q;
  assign tbc.tbc_data  = data_q;

endmodule

// File: tb/tb_ixc_tbcall_sched.sv
// Directed bench for ixc_tbcall_sched: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever done is presented.
module tb_ixc_tbcall_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned TW   = 16;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [DW-1:0]   rsp;
    logic            err;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rsp_data;
  logic               err_timeout;
  logic [TW-1:0]      timeout_cycles;
  logic               stray_ack;

  ixc_tbcall_sched_if #(.DW(DW)) tbc_if ();

  ixc_tbcall_sched #(.NREQ(NREQ), .DW(DW), .TW(TW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_i            (req),
    .req_data_i       (req_data),
    .gnt_o            (gnt),
    .done_o           (done),
    .rsp_data_o       (rsp_data),
    .err_timeout_o    (err_timeout),
    .timeout_cycles_i (timeout_cycles),
    .stray_ack_o      (stray_ack),
    .tbc              (tbc_if)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [NREQ-1:0] prev_done = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_done(input logic [NREQ-1:0] g, input logic [DW-1:0] r, input logic e);
    exp_t x;
    x.gnt = g;
    x.rsp = r;
    x.err = e;
    exp_q.push_back(x);
  endtask

  // Scoreboard monitor: every done presentation must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=%b, expected no completion", done);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_vec", 64'(done), 64'(mon_e.gnt));
        check("rsp_data", 64'(rsp_data), 64'(mon_e.rsp));
        check("err_timeout", 64'(err_timeout), 64'(mon_e.err));
        check("done_single_pulse", 64'(prev_done), 64'(0));
      end
    end
    prev_done <= done;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_rsp"}, 64'(rsp_data), 64'(0));
    check({tag, "_err"}, 64'(err_timeout), 64'(0));
    check({tag, "_valid"}, 64'(tbc_if.tbc_valid), 64'(0));
    check({tag, "_data"}, 64'(tbc_if.tbc_data), 64'(0));
    check({tag, "_stray"}, 64'(stray_ack), 64'(0));
  endtask

  // Channel-side responder: waits for the call, holds ready low rdy_wait cycles,
  // then acks after ack_wait WAIT cycles (ack_wait < 0 leaves the call in WAIT)
  task automatic serve(input logic [NREQ-1:0] exp_gnt, input logic [DW-1:0] exp_data,
                       input int rdy_wait, input int ack_wait, input logic [DW-1:0] rsp);
    int n;
    int vcnt;
    n = 0;
    while (tbc_if.tbc_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("issue_seen", 64'(n < 20), 64'(1));
    check("tbc_data", 64'(tbc_if.tbc_data), 64'(exp_data));
    check("gnt", 64'(gnt), 64'(exp_gnt));
    vcnt = 1;
    for (int i = 0; i < rdy_wait; i++) begin
      tbc_if.tbc_ready = 1'b0;
      @(negedge clk);
      if (tbc_if.tbc_valid === 1'b1 && tbc_if.tbc_data === exp_data && done === '0) vcnt++;
    end
    if (rdy_wait > 0) check("valid_stable_cycles", 64'(vcnt), 64'(rdy_wait + 1));
    tbc_if.tbc_ready = 1'b1;
    @(negedge clk);
    tbc_if.tbc_ready = 1'b0;
    check("valid_low_in_wait", 64'(tbc_if.tbc_valid), 64'(0));
    if (ack_wait >= 0) begin
      for (int i = 0; i < ack_wait; i++) @(negedge clk);
      tbc_if.tbc_ack = 1'b1;
      tbc_if.tbc_rsp = rsp;
      @(negedge clk);
      tbc_if.tbc_ack = 1'b0;
      tbc_if.tbc_rsp = 32'hDEAD_BEEF;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected earlier completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int start;
    logic [NREQ-1:0] g;

    rst_n            = 1'b0;
    req              = '0;
    req_data         = '0;
    timeout_cycles   = '0;
    tbc_if.tbc_ready = 1'b0;
    tbc_if.tbc_ack   = 1'b0;
    tbc_if.tbc_rsp   = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness: all four requesting, grants rotate 0,1,2,3,0,1,2,3
    for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = 32'hA000_0000 + 32'(i);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      g = NREQ'(1) << (k % 4);
      expect_done(g, 32'h5000_0000 + 32'(k), 1'b0);
      serve(g, 32'hA000_0000 + 32'(k % 4), 0, 0, 32'h5000_0000 + 32'(k));
      if (k == 7) req = '0;
    end
    repeat (2) @(negedge clk);

    // Single call: done lands in the fourth cycle, i.e. three edges after the IDLE sample
    req_data[1*DW +: DW] = 32'hCAFE_0001;
    req   = 4'b0010;
    start = cyc;
    expect_done(4'b0010, 32'h1234_5678, 1'b0);
    serve(4'b0010, 32'hCAFE_0001, 0, 0, 32'h1234_5678);
    check("latency_edges", 64'(cyc - start), 64'(3));
    check("single_done_now", 64'(done), 64'(4'b0010));
    req = '0;
    repeat (2) @(negedge clk);

    // Backpressure: 10 cycles of ready low, short timeout must not fire in ISSUE
    timeout_cycles       = 16'd3;
    req_data[2*DW +: DW] = 32'hB0B0_0002;
    req = 4'b0100;
    expect_done(4'b0100, 32'h7777_0003, 1'b0);
    serve(4'b0100, 32'hB0B0_0002, 10, 0, 32'h7777_0003);
    req = '0;
    repeat (2) @(negedge clk);

    // Timeout of 5: exactly five WAIT cycles, mid-call limit change ignored
    timeout_cycles       = 16'd5;
    req_data[0*DW +: DW] = 32'hC0DE_0000;
    req = 4'b0001;
    expect_done(4'b0001, 32'h0, 1'b1);
    serve(4'b0001, 32'hC0DE_0000, 0, -1, 32'h0);
    timeout_cycles = 16'd1;
    n = 0;
    while (done === '0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("timeout_wait_cycles", 64'(n), 64'(5));
    req = '0;
    repeat (2) @(negedge clk);

    // Timeout disabled: 1000 silent WAIT cycles, req dropped after grant still completes
    timeout_cycles = 16'd0;
    req = 4'b0010;
    expect_done(4'b0010, 32'h0000_1000, 1'b0);
    serve(4'b0010, 32'hCAFE_0001, 0, -1, 32'h0);
    req = '0;
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (done !== '0 || tbc_if.tbc_valid !== 1'b0) n++;
    end
    check("no_timeout_when_zero", 64'(n), 64'(0));
    tbc_if.tbc_ack = 1'b1;
    tbc_if.tbc_rsp = 32'h0000_1000;
    @(negedge clk);
    tbc_if.tbc_ack = 1'b0;
    tbc_if.tbc_rsp = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);

    // Ack on the timeout cycle (third WAIT cycle with limit 3): ack wins
    timeout_cycles       = 16'd3;
    req_data[3*DW +: DW] = 32'hD00D_0003;
    req = 4'b1000;
    expect_done(4'b1000, 32'h5A5A_5A5A, 1'b0);
    serve(4'b1000, 32'hD00D_0003, 0, 2, 32'h5A5A_5A5A);
    req = '0;
    repeat (2) @(negedge clk);

    // Stray ack in IDLE: sticky flag, no completion
    check("stray_before", 64'(stray_ack), 64'(0));
    tbc_if.tbc_ack = 1'b1;
    @(negedge clk);
    tbc_if.tbc_ack = 1'b0;
    check("stray_set", 64'(stray_ack), 64'(1));
    repeat (3) @(negedge clk);
    check("stray_sticky", 64'(stray_ack), 64'(1));
    check("stray_no_done", 64'(done), 64'(0));

    // Reset in WAIT: outputs clear asynchronously, abandoned call never completes
    timeout_cycles = 16'd0;
    req = 4'b0100;
    serve(4'b0100, 32'hB0B0_0002, 0, -1, 32'h0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    req = 4'b1000;
    @(negedge clk);
    rst_n = 1'b1;
    expect_done(4'b1000, 32'h0000_BEEF, 1'b0);
    serve(4'b1000, 32'hD00D_0003, 0, 0, 32'h0000_BEEF);
    req = '0;
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
